top_16_64: RTL and testbench



---
 rtl/top_16_64_pkg.sv | 49 ++++
 rtl/top_16_64_cla_16.sv | 50 +++++
 rtl/top_16_64.sv | 58 +++++
 tb/tb_top_16_64.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/top_16_64_pkg.sv
// Shared widths, result payload and carry-lookahead helper functions for the
// 64-bit two-level CLA adder.
package top_16_64_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned BLK_W  = 16;
  localparam int unsigned GRP_W  = 4;
  localparam int unsigned N_BLK  = DATA_W / BLK_W;
  localparam int unsigned N_GRP  = BLK_W / GRP_W;
  localparam int unsigned LA_W   = 4;

  typedef struct packed {
    logic [DATA_W-1:0] sum;
    logic              cout;
  } add_res_t;

  // Group generate across four (g, p) pairs, bit 3 most significant.
  function automatic logic la_gen(input logic [LA_W-1:0] g, input logic [LA_W-1:0] p);
    la_gen = g[3]
           | (p[3] & g[2])
           | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  // Group propagate across four (g, p) pairs.
  function automatic logic la_prop(input logic [LA_W-1:0] p);
    la_prop = &p;
  endfunction

  // Flat lookahead carries into positions 0..3 from four (g, p) pairs and c0.
  function automatic logic [LA_W-1:0] la_carries(input logic [LA_W-1:0] g,
                                                 input logic [LA_W-1:0] p,
                                                 input logic            c0);
    logic [LA_W-1:0] c;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    la_carries = c;
  endfunction

  // Carry out of the fourth position, expressed without rippling.
  function automatic logic la_cout(input logic [LA_W-1:0] g,
                                   input logic [LA_W-1:0] p,
                                   input logic            c0);
    la_cout = la_gen(g, p) | (la_prop(p) & c0);
  endfunction

endpackage

// File: rtl/top_16_64_cla_16.sv
// 16-bit carry-lookahead block: four 4-bit lookahead groups plus an in-block
// lookahead; exports block generate/propagate for the second level.
module cla_16
  import top_16_64_pkg::*;
(
  input  logic [BLK_W-1:0] a_i,
  input  logic [BLK_W-1:0] b_i,
  input  logic             cin_i,
  output logic [BLK_W-1:0] sum_c_o,
  output logic             g16_c_o,
  output logic             p16_c_o
);

  logic [BLK_W-1:0] g;
  logic [BLK_W-1:0] p;
  logic [BLK_W-1:0] c;
  logic [N_GRP-1:0] gg;
  logic [N_GRP-1:0] pg;
  logic [N_GRP-1:0] cg;
  logic [GRP_W-1:0] cl;

  // Bit and group generate/propagate; independent of cin so the level-2
  // unit sees G16/P16 without any dependence on its own carry outputs.
  always_comb begin : gp_comb
    g  = a_i & b_i;
    p  = a_i ^ b_i;
    gg = '0;
    pg = '0;
    for (int k = 0; k < int'(N_GRP); k++) begin
      gg[k] = la_gen(g[k*GRP_W +: GRP_W], p[k*GRP_W +: GRP_W]);
      pg[k] = la_prop(p[k*GRP_W +: GRP_W]);
    end
  end

  assign g16_c_o = la_gen(gg, pg);
  assign p16_c_o = la_prop(pg);

  // Group carries from the block carry-in, then bit carries inside each group.
  always_comb begin : carry_comb
    cg = la_carries(gg, pg, cin_i);
    c  = '0;
    cl = '0;
    for (int k = 0; k < int'(N_GRP); k++) begin
      cl = la_carries(g[k*GRP_W +: GRP_W], p[k*GRP_W +: GRP_W], cg[k]);
      c[k*GRP_W +: GRP_W] = cl;
    end
    sum_c_o = p ^ c;
  end

endmodule

// File: rtl/top_16_64.sv
// 64-bit registered adder: four cla_16 blocks joined by a level-2 lookahead
// unit, with sum and carry-out captured one cycle after the inputs.
module top_16_64
  import top_16_64_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] sum,
  output logic              cout,
  input  logic              clk,
  input  logic              rst
);

  logic [N_BLK-1:0]  g16;
  logic [N_BLK-1:0]  p16;
  logic [N_BLK-1:0]  cblk;
  logic [DATA_W-1:0] s_c;
  logic              c64;
  add_res_t          res_d;
  add_res_t          res_q;

  // Level 2: every block carry-in comes from here, none ripple between blocks.
  always_comb begin : level2_comb
    cblk = la_carries(g16, p16, cin);
    c64  = la_cout(g16, p16, cin);
  end

  for (genvar k = 0; k < int'(N_BLK); k++) begin : g_blk
    cla_16 u_cla_16 (
      .a_i     (a[k*BLK_W +: BLK_W]),
      .b_i     (b[k*BLK_W +: BLK_W]),
      .cin_i   (cblk[k]),
      .sum_c_o (s_c[k*BLK_W +: BLK_W]),
      .g16_c_o (g16[k]),
      .p16_c_o (p16[k])
    );
  end

  always_comb begin : res_comb
    res_d      = '0;
    res_d.sum  = s_c;
    res_d.cout = c64;
  end

  // Output register; a low rst at an edge discards the in-flight result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign sum  = res_q.sum;
  assign cout = res_q.cout;

endmodule

// File: tb/tb_top_16_64.sv
// Scoreboard bench for top_16_64: stimulus pushes expected results, a monitor
// pops and compares one cycle later.
module tb_top_16_64;

  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic [63:0] sum;
  logic        cout;
  logic        clk;
  logic        rst;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    int          id;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_push  = 0;

  top_16_64 dut (
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout),
    .clk  (clk),
    .rst  (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one vector at the falling edge and push its hand-given expectation.
  task automatic apply(input logic [63:0] va, input logic [63:0] vb, input logic vc,
                       input logic vr, input logic [63:0] es, input logic ec, input int id);
    exp_t e;
    @(negedge clk);
    a   = va;
    b   = vb;
    cin = vc;
    rst = vr;
    e.sum  = es;
    e.cout = ec;
    e.id   = id;
    q.push_back(e);
    n_push++;
  endtask

  // Drive one vector with the expectation from a 65-bit reference add.
  task automatic apply_ref(input logic [63:0] va, input logic [63:0] vb, input logic vc,
                           input logic vr, input int id);
    logic [64:0] full;
    full = {1'b0, va} + {1'b0, vb} + 65'(vc);
    if (!vr) full = '0;
    apply(va, vb, vc, vr, full[63:0], full[64], id);
  endtask

  // Monitor: one result per rising edge, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_tests++;
        if (sum !== e.sum || cout !== e.cout) begin
          n_fail++;
          $display("FAIL vec%0d: got sum=%h cout=%b, expected sum=%h cout=%b",
                   e.id, sum, cout, e.sum, e.cout);
        end
      end
    end
  end

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rc;
    logic        rr;
    int          guard;
    a   = '0;
    b   = '0;
    cin = 1'b0;
    rst = 1'b0;

    apply(ONES, ONES, 1'b1, 1'b0, 64'h0, 1'b0, 1);
    apply(ONES, ONES, 1'b1, 1'b0, 64'h0, 1'b0, 2);
    apply(ONES, ONES, 1'b1, 1'b1, ONES, 1'b1, 3);

    apply(64'd2,   64'd5,   1'b0, 1'b1, 64'd7,   1'b0, 10);
    apply(64'd1,   64'd1,   1'b0, 1'b1, 64'd2,   1'b0, 11);
    apply(64'd20,  64'd20,  1'b1, 1'b1, 64'd41,  1'b0, 12);
    apply(64'd75,  64'd75,  1'b1, 1'b1, 64'd151, 1'b0, 13);
    apply(64'd128, 64'd128, 1'b0, 1'b1, 64'd256, 1'b0, 14);
    apply(64'd200, 64'd20,  1'b0, 1'b1, 64'd220, 1'b0, 15);

    apply(64'd2232300, 64'd9890809, 1'b1, 1'b1, 64'd12123110, 1'b0, 20);
    apply(64'd2232300, 64'd9890809, 1'b0, 1'b1, 64'd12123109, 1'b0, 21);

    apply(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b1, 64'h0000_0000_0001_0000, 1'b0, 30);
    apply(64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 64'h0001_0000_0000_0000, 1'b0, 31);
    apply(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 64'h0000_0001_0000_0000, 1'b0, 32);
    apply(64'hFFFF_0000_0000_0000, 64'h0001_0000_0000_0000, 1'b0, 1'b1, 64'h0, 1'b1, 33);

    apply(ONES, 64'h0, 1'b1, 1'b1, 64'h0, 1'b1, 40);
    apply(ONES, 64'h0, 1'b0, 1'b1, ONES,  1'b0, 41);

    // Back-to-back random traffic with a two-cycle reset pulse mid-stream.
    for (int i = 0; i < 10000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(1, 0));
      rr = !(i == 5000 || i == 5001);
      apply_ref(ra, rb, rc, rr, 1000 + i);
    end

    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d results still pending, expected 0", q.size());
    end
    if (n_tests != n_push) begin
      n_fail++;
      $display("FAIL count: checked %0d results, expected %0d", n_tests, n_push);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
